// File: rtl/ddr3_frame_reader.sv
// ddr3_frame_reader
// -----------------------------------------------------------------------------
// DDR3 Avalon-MM read master for the VGA scan-out path. It streams whole frames
// from one of NUM_BUFFERS frame buffers into the downstream pixel FIFO, issuing
// bursts of BURST_LEN 128-bit beats. A credit check against the FIFO's free-word
// count stops it from requesting more beats than the FIFO can take. When the
// optional debug port is built, it also services single-beat debug reads.
//
// Optional feature macro: DDR3_RD_TEST_PORT_EN
//   defined   : debug read path (test_rd / test_rd_data / test_done) present
//   undefined : test_rd ignored, test_rd_data and test_done tied to 0
//
// Ports
//   ddr3_clk, ddr3_reset_n     clock, asynchronous active-low reset
//   buf_full[NUM_BUFFERS]      buffer i holds a complete frame (level)
//   buf_offset[26*NUM_BUFFERS] packed beat-address base of each buffer
//   buf_clear[NUM_BUFFERS]     one-cycle pulse, buffer released to the writer
//   fifo_free[FIFO_AW+1]       free words in the pixel FIFO
//   rd_data/rd_valid           frame beats to the FIFO
//   frame_done                 pulse with the last beat of a frame
//   test_addr/test_rd          debug read request
//   test_rd_data/test_done     debug read result (held) and update pulse
//   ddr3_avl_*                 Avalon-MM read master
module ddr3_frame_reader #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int NUM_BUFFERS  = 2,
  parameter int BURST_LEN    = 4,
  parameter int FIFO_AW      = 9
) (
  input  logic                     ddr3_clk,
  input  logic                     ddr3_reset_n,
  input  logic [NUM_BUFFERS-1:0]   buf_full,
  input  logic [26*NUM_BUFFERS-1:0] buf_offset,
  output logic [NUM_BUFFERS-1:0]   buf_clear,
  input  logic [FIFO_AW:0]         fifo_free,
  output logic [127:0]             rd_data,
  output logic                     rd_valid,
  output logic                     frame_done,
  input  logic [25:0]              test_addr,
  input  logic                     test_rd,
  output logic [127:0]             test_rd_data,
  output logic                     test_done,
  input  logic                     ddr3_avl_ready,
  output logic                     ddr3_avl_burstbegin,
  output logic                     ddr3_avl_read_req,
  output logic [25:0]              ddr3_avl_addr,
  output logic [2:0]               ddr3_avl_size,
  input  logic                     ddr3_avl_read_data_valid,
  input  logic [127:0]             ddr3_avl_read_data
);

  localparam int BURSTS = IMAGE_WIDTH * IMAGE_HEIGHT / (4 * BURST_LEN);
  localparam int BEATS  = BURSTS * BURST_LEN;
  localparam int CW     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BUFW   = $clog2(NUM_BUFFERS);
  localparam int OW     = FIFO_AW + 1;
  localparam int CMPW   = FIFO_AW + 2;

`ifdef DDR3_RD_TEST_PORT_EN
  typedef enum logic [2:0] {IDLE, FRAME_WAIT, FRAME_REQ, TEST_REQ, TEST_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FRAME_WAIT, FRAME_REQ} state_t;
`endif

  state_t          state, state_next;
  logic [BUFW-1:0] cur, nxt, sel_idx;
  logic            have_frame;
  logic [OW-1:0]   outstanding, outstanding_next;
  logic [CW-1:0]   count;
  logic [BW-1:0]   beat_cnt;
  logic            sel, sel_switch, start_test;
  logic            accept, frame_accept, frame_beat, test_beat;
  logic            credit_ok, credit_ok_next;
  logic [25:0]     offsets [NUM_BUFFERS];

  // Unpack the per-buffer base addresses.
  for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_off
    assign offsets[gi] = buf_offset[26*gi +: 26];
  end

  assign nxt          = (cur == BUFW'(NUM_BUFFERS - 1)) ? '0 : cur + 1'b1;
  assign accept       = ddr3_avl_read_req && ddr3_avl_ready;
  assign frame_accept = accept && (state == FRAME_REQ);

`ifdef DDR3_RD_TEST_PORT_EN
  assign test_beat = ddr3_avl_read_data_valid && (state == TEST_WAIT);
`else
  assign test_beat = 1'b0;
`endif

  // Beats arriving with nothing outstanding (e.g. in flight across a reset)
  // are dropped rather than forwarded to the FIFO.
  assign frame_beat = ddr3_avl_read_data_valid && !test_beat && (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    if (frame_accept) outstanding_next = outstanding_next + OW'(BURST_LEN);
    if (frame_beat)   outstanding_next = outstanding_next - OW'(1);
  end

  assign credit_ok      = {1'b0, fifo_free} >= ({1'b0, outstanding} + CMPW'(BURST_LEN));
  assign credit_ok_next = {1'b0, fifo_free} >= ({1'b0, outstanding_next} + CMPW'(BURST_LEN));

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    sel        = 1'b0;
    sel_switch = 1'b0;
    sel_idx    = cur;
    start_test = 1'b0;
    case (state)
      IDLE: begin
`ifdef DDR3_RD_TEST_PORT_EN
        // A debug read only goes out once every frame beat has come back,
        // so its data cannot be confused with frame data.
        if (test_pend && outstanding == '0) begin
          start_test = 1'b1;
          state_next = TEST_REQ;
        end else
`endif
        if (buf_full[nxt]) begin
          sel        = 1'b1;
          sel_switch = 1'b1;
          sel_idx    = nxt;
          state_next = FRAME_WAIT;
        end else if (buf_full[cur]) begin
          sel        = 1'b1;
          state_next = FRAME_WAIT;
        end
      end
      FRAME_WAIT: if (credit_ok) state_next = FRAME_REQ;
      FRAME_REQ: begin
        if (accept) begin
          if (count == CW'(BURSTS - 1)) state_next = IDLE;
          else if (credit_ok_next)      state_next = FRAME_REQ;
          else                          state_next = FRAME_WAIT;
        end
      end
`ifdef DDR3_RD_TEST_PORT_EN
      TEST_REQ:  if (accept) state_next = TEST_WAIT;
      TEST_WAIT: if (ddr3_avl_read_data_valid) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      cur                 <= '0;
      have_frame          <= 1'b0;
      outstanding         <= '0;
      count               <= '0;
      beat_cnt            <= '0;
      buf_clear           <= '0;
      rd_data             <= '0;
      rd_valid            <= 1'b0;
      frame_done          <= 1'b0;
      ddr3_avl_read_req   <= 1'b0;
      ddr3_avl_burstbegin <= 1'b0;
      ddr3_avl_addr       <= '0;
      ddr3_avl_size       <= '0;
    end else begin
      outstanding <= outstanding_next;
      buf_clear   <= '0;

      if (sel) begin
        if (sel_switch) begin
          cur <= nxt;
          // The very first frame after reset releases nothing.
          if (have_frame) buf_clear[cur] <= 1'b1;
        end
        ddr3_avl_addr <= offsets[sel_idx];
        ddr3_avl_size <= 3'(BURST_LEN);
        count         <= '0;
        have_frame    <= 1'b1;
      end else if (frame_accept && count != CW'(BURSTS - 1)) begin
        ddr3_avl_addr <= ddr3_avl_addr + 26'(BURST_LEN);
        count         <= count + 1'b1;
      end
`ifdef DDR3_RD_TEST_PORT_EN
      if (start_test) begin
        ddr3_avl_addr <= test_addr;
        ddr3_avl_size <= 3'd1;
      end
      ddr3_avl_read_req   <= (state_next == FRAME_REQ) || (state_next == TEST_REQ);
      ddr3_avl_burstbegin <= (state_next == FRAME_REQ) || (state_next == TEST_REQ);
`else
      ddr3_avl_read_req   <= (state_next == FRAME_REQ);
      ddr3_avl_burstbegin <= (state_next == FRAME_REQ);
`endif

      rd_valid   <= frame_beat;
      frame_done <= frame_beat && (beat_cnt == BW'(BEATS - 1));
      if (frame_beat) begin
        rd_data  <= ddr3_avl_read_data;
        beat_cnt <= (beat_cnt == BW'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

`ifdef DDR3_RD_TEST_PORT_EN
  logic test_pend;

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      test_pend    <= 1'b0;
      test_rd_data <= '0;
      test_done    <= 1'b0;
    end else begin
      // Clearing on entry wins: a pulse in that same cycle is absorbed.
      if (start_test)   test_pend <= 1'b0;
      else if (test_rd) test_pend <= 1'b1;
      test_done <= test_beat;
      if (test_beat) test_rd_data <= ddr3_avl_read_data;
    end
  end
`else
  logic unused_test;
  assign unused_test  = ^{test_rd, test_addr, start_test, test_beat};
  assign test_rd_data = '0;
  assign test_done    = 1'b0;
`endif

endmodule
